audio_stream_bridge: RTL and testbench
======================================

AUDIO_STREAM_BRIDGE -- requirements
Module: audio_stream_bridge

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; the ports are named CLOCK_50 and resetn.
REQ-002 Parameters SHALL be:
- FX_LATENCY, default 0: cycles the effect chain needs after fx_valid (legal 0..15).
- STALL_LIMIT, default 1023: WAIT_OUT cycles tolerated before a sample is dropped (legal 1..65535).
REQ-003 Ports SHALL be:
- CLOCK_50  in  1  system clock
- resetn  in  1  async active-low reset
- bypass  in  1  route captured codec sample straight to output
- audio_in_available  in  1  codec input FIFO non-empty
- read_audio_in  out  1  one-cycle pop of codec input FIFO
- codec_left_in, codec_right_in  in  32 each  codec samples (show-ahead)
- fx_left_out, fx_right_out  out  32 each  held sample to effect chain
- fx_valid  out  1  one-cycle strobe: new fx_*_out sample
- fx_left_in, fx_right_in  in  32 each  processed sample from effect chain
- audio_out_allowed  in  1  codec output FIFO has space
- write_audio_out  out  1  one-cycle push to codec output FIFO
- codec_left_out, codec_right_out  out  32 each  sample to codec
- drop_count  out  16  saturating count of dropped samples

Function
REQ-004 The FSM SHALL have states IDLE, CAPTURE, PROCESS, WAIT_OUT, WRITE.
REQ-005 IDLE SHALL go to CAPTURE when audio_in_available=1; otherwise it SHALL hold.
REQ-006 CAPTURE SHALL last exactly one cycle with read_audio_in=1.
- At its closing edge, codec_*_in SHALL be latched into fx_*_out.
- The state SHALL then go to PROCESS.
REQ-007 fx_*_out SHALL stay stable from the CAPTURE edge until the next CAPTURE edge.
REQ-008 PROCESS SHALL last FX_LATENCY+1 cycles.
- fx_valid=1 only in the first PROCESS cycle.
- At the closing edge of the last PROCESS cycle, codec_*_out SHALL load fx_*_in, or fx_*_out when bypass=1.
- The state SHALL then go to WAIT_OUT.
REQ-009 bypass SHALL be sampled only at the REQ-008 load edge; changes at other times SHALL have no effect on the sample in flight.
REQ-010 In WAIT_OUT:
- audio_out_allowed=1 SHALL move the state to WRITE.
- Otherwise a 16-bit stall counter SHALL increment.
- When the counter equals STALL_LIMIT, the sample SHALL be dropped: go to IDLE, drop_count+1, no write pulse.
REQ-011 WRITE SHALL last exactly one cycle with write_audio_out=1 and codec_*_out stable, then go to IDLE.
REQ-012 The stall counter SHALL clear on every entry to WAIT_OUT.
REQ-013 drop_count SHALL saturate at 16'hFFFF with no wrap.
REQ-014 read_audio_in and write_audio_out SHALL never be high in the same cycle, and each SHALL be high at most one cycle per sample.
REQ-015 audio_in_available rising during PROCESS, WAIT_OUT or WRITE SHALL be ignored until IDLE; the codec FIFO buffers it and no sample is lost.
REQ-016 Minimum period SHALL be FX_LATENCY+5 cycles per sample with audio_out_allowed held 1.
REQ-017 Sample data SHALL pass unmodified; the sign bit and all 32 bits are preserved in bypass.
REQ-018 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-019 resetn=0 SHALL asynchronously force:
- state IDLE;
- read_audio_in, write_audio_out, fx_valid = 0;
- fx_*_out, codec_*_out = 0;
- stall counter, latency counter, drop_count = 0.
REQ-020 Reset mid-sample SHALL abandon the sample with no write pulse; after deassertion the FSM SHALL restart from IDLE.

Structure
REQ-021 Package audio_pkg SHALL hold:
- the state enum;
- SAMPLE_W=32;
- DROP_W=16;
- default FX_LATENCY and STALL_LIMIT constants.
REQ-022 drop_count SHALL be implemented in one sub-module, sat_counter (width-parameterised, increment enable, async active-low clear); everything else stays in audio_stream_bridge.

Verification
REQ-023 Nominal, FX_LATENCY=2, audio_out_allowed=1:
- Stimulus: available at cycle 0, codec_left_in=32'h0000_1234, fx_left_in=32'h0000_0ABC.
- Response: read at cycle 1, fx_valid at cycle 2, write at cycle 6 with codec_left_out=32'h0000_0ABC.
REQ-024 Bypass:
- Stimulus: bypass=1, codec_right_in=32'h8000_0005.
- Response: write with codec_right_out=32'h8000_0005, regardless of fx_right_in.
REQ-025 Back-pressure:
- Stimulus: audio_out_allowed=0 for 10 cycles, then 1.
- Response: exactly one write, on the cycle after allowed rises; drop_count=0.
REQ-026 Drop:
- Stimulus: STALL_LIMIT=4, audio_out_allowed stuck at 0.
- Response: return to IDLE after 4 WAIT_OUT cycles, drop_count=1, no write.
- Extended check: a forced preload near 16'hFFFF shows saturation at 16'hFFFF.
REQ-027 Reset mid-PROCESS:
- Stimulus: resetn low in PROCESS.
- Response: all outputs 0 immediately; no write; the next sample is processed normally.
REQ-028 Continuous input:
- Stimulus: audio_in_available held 1 for 100 samples, FX_LATENCY=0.
- Response: 100 reads and 100 writes, with period 5 cycles.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio stream bridge
package audio_pkg;

    localparam int SAMPLE_W        = 32;
    localparam int DROP_W          = 16;
    localparam int FX_LATENCY_DEF  = 0;
    localparam int STALL_LIMIT_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_PROCESS,
        ST_WAIT_OUT,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/audio_stream_bridge.sv
// rtl/audio_stream_bridge.sv - codec-in -> effect chain -> codec-out sample sequencer
module audio_stream_bridge
    import audio_pkg::*;
#(
    parameter int FX_LATENCY  = FX_LATENCY_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                bypass,
    input  logic                audio_in_available,
    output logic                read_audio_in,
    input  logic [SAMPLE_W-1:0] codec_left_in,
    input  logic [SAMPLE_W-1:0] codec_right_in,
    output logic [SAMPLE_W-1:0] fx_left_out,
    output logic [SAMPLE_W-1:0] fx_right_out,
    output logic                fx_valid,
    input  logic [SAMPLE_W-1:0] fx_left_in,
    input  logic [SAMPLE_W-1:0] fx_right_in,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] codec_left_out,
    output logic [SAMPLE_W-1:0] codec_right_out,
    output logic [DROP_W-1:0]   drop_count
);

    localparam logic [3:0]  LAT_LAST   = 4'(FX_LATENCY);
    localparam logic [15:0] STALL_LAST = 16'(STALL_LIMIT - 1);

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [15:0] stall_cnt;
    logic        drop;

    // The sample is abandoned on the edge where the incremented stall count reaches the limit.
    assign drop = (state == ST_WAIT_OUT) && !audio_out_allowed && (stall_cnt == STALL_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            fx_valid        <= 1'b0;
            fx_left_out     <= '0;
            fx_right_out    <= '0;
            codec_left_out  <= '0;
            codec_right_out <= '0;
            lat_cnt         <= '0;
            stall_cnt       <= '0;
        end else begin
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            fx_valid        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (audio_in_available) begin
                        state         <= ST_CAPTURE;
                        read_audio_in <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    fx_left_out  <= codec_left_in;
                    fx_right_out <= codec_right_in;
                    fx_valid     <= 1'b1;
                    lat_cnt      <= '0;
                    state        <= ST_PROCESS;
                end
                ST_PROCESS: begin
                    if (lat_cnt == LAT_LAST) begin
                        codec_left_out  <= bypass ? fx_left_out  : fx_left_in;
                        codec_right_out <= bypass ? fx_right_out : fx_right_in;
                        stall_cnt       <= '0;
                        state           <= ST_WAIT_OUT;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_WAIT_OUT: begin
                    if (audio_out_allowed) begin
                        write_audio_out <= 1'b1;
                        state           <= ST_WRITE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (drop) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(DROP_W)
    ) u_drop_count (
        .clk   (CLOCK_50),
        .clr_n (resetn),
        .inc   (drop),
        .count (drop_count)
    );

endmodule

// File: tb/tb_audio_stream_bridge.sv
// tb/tb_audio_stream_bridge.sv - self-checking bench for audio_stream_bridge
module tb_audio_stream_bridge;

    localparam int MAXC = 1100;

    typedef struct {
        int          d;
        bit          by;
        logic [31:0] cl, cr, fl, fr, el, er;
        int          wc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        byp  [2];
    logic        avail[2];
    logic        allow[2];
    logic [31:0] cin_l[2], cin_r[2], fin_l[2], fin_r[2];
    logic        rd[2], wr[2], fv[2];
    logic [31:0] fo_l[2], fo_r[2], co_l[2], co_r[2];
    logic [15:0] drops[2];

    logic       sat_clr;
    logic       sat_inc;
    logic [3:0] sat_q;

    audio_stream_bridge #(.FX_LATENCY(2)) dut_a (
        .CLOCK_50(clk), .resetn(rstn[0]), .bypass(byp[0]), .audio_in_available(avail[0]),
        .read_audio_in(rd[0]), .codec_left_in(cin_l[0]), .codec_right_in(cin_r[0]),
        .fx_left_out(fo_l[0]), .fx_right_out(fo_r[0]), .fx_valid(fv[0]),
        .fx_left_in(fin_l[0]), .fx_right_in(fin_r[0]), .audio_out_allowed(allow[0]),
        .write_audio_out(wr[0]), .codec_left_out(co_l[0]), .codec_right_out(co_r[0]),
        .drop_count(drops[0]));

    audio_stream_bridge #(.FX_LATENCY(0), .STALL_LIMIT(4)) dut_b (
        .CLOCK_50(clk), .resetn(rstn[1]), .bypass(byp[1]), .audio_in_available(avail[1]),
        .read_audio_in(rd[1]), .codec_left_in(cin_l[1]), .codec_right_in(cin_r[1]),
        .fx_left_out(fo_l[1]), .fx_right_out(fo_r[1]), .fx_valid(fv[1]),
        .fx_left_in(fin_l[1]), .fx_right_in(fin_r[1]), .audio_out_allowed(allow[1]),
        .write_audio_out(wr[1]), .codec_left_out(co_l[1]), .codec_right_out(co_r[1]),
        .drop_count(drops[1]));

    sat_counter #(.W(4)) u_sat (.clk(clk), .clr_n(sat_clr), .inc(sat_inc), .count(sat_q));

    int vectors = 0;
    int miscompares = 0;

    bit          h_av[MAXC], h_al[MAXC], h_by[MAXC];
    logic [31:0] h_cl[MAXC], h_cr[MAXC], h_fl[MAXC], h_fr[MAXC];
    bit          o_rd[MAXC], o_wr[MAXC], o_fv[MAXC];
    logic [31:0] o_fl[MAXC], o_fr[MAXC], o_cl[MAXC], o_cr[MAXC];
    logic [15:0] o_drop;
    bit          e_rd[MAXC], e_wr[MAXC], e_fv[MAXC];
    logic [31:0] e_fl[MAXC], e_fr[MAXC], e_wl[MAXC], e_wrr[MAXC];
    int          e_drops;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int d, input int c);
        byp[d]   = (c < 0) ? 1'b0  : h_by[c];
        avail[d] = (c < 0) ? 1'b0  : h_av[c];
        allow[d] = (c < 0) ? 1'b0  : h_al[c];
        cin_l[d] = (c < 0) ? 32'd0 : h_cl[c];
        cin_r[d] = (c < 0) ? 32'd0 : h_cr[c];
        fin_l[d] = (c < 0) ? 32'd0 : h_fl[c];
        fin_r[d] = (c < 0) ? 32'd0 : h_fr[c];
    endtask

    task automatic check_zero(input string nm, input int d);
        check({nm, " strobes"}, 32'({rd[d], wr[d], fv[d]}), 32'd0);
        check({nm, " data"}, fo_l[d] | fo_r[d] | co_l[d] | co_r[d], 32'd0);
        check({nm, " drops"}, 32'(drops[d]), 32'd0);
    endtask

    task automatic fill(input int p_av, input int p_al, input int p_by);
        for (int c = 0; c < MAXC; c++) begin
            h_av[c] = (int'($urandom_range(99)) < p_av);
            h_al[c] = (int'($urandom_range(99)) < p_al);
            h_by[c] = (int'($urandom_range(99)) < p_by);
            h_cl[c] = $urandom;
            h_cr[c] = $urandom;
            h_fl[c] = $urandom;
            h_fr[c] = $urandom;
        end
    endtask

    // Reset, then replay the stimulus history one cycle at a time; abort >= 0 pulses reset mid-run.
    task automatic run(input int d, input int n, input int abort);
        rstn[d] = 1'b0;
        set_in(d, -1);
        @(posedge clk); #1;
        check_zero("reset", d);
        rstn[d] = 1'b1;
        for (int c = 0; c < n; c++) begin
            set_in(d, c);
            @(negedge clk);
            o_rd[c] = rd[d]; o_wr[c] = wr[d]; o_fv[c] = fv[d];
            o_fl[c] = fo_l[d]; o_fr[c] = fo_r[d]; o_cl[c] = co_l[d]; o_cr[c] = co_r[d];
            o_drop  = drops[d];
            if (c == abort) begin
                rstn[d] = 1'b0;
                #1;
                check_zero("async reset", d);
            end
            @(posedge clk); #1;
            if (c == abort) rstn[d] = 1'b1;
        end
        set_in(d, -1);
    endtask

    // Sample-level reference: each sample walks capture, latency, output window in plain cycle arithmetic.
    task automatic model(input int lat, input int lim, input int n);
        int t, r, ld, ws, w;
        bit found;
        logic [31:0] dl, dr;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_wr[c] = 0; e_fv[c] = 0;
            e_fl[c] = 0; e_fr[c] = 0; e_wl[c] = 0; e_wrr[c] = 0;
        end
        e_drops = 0;
        t = 0;
        while (t < n) begin
            if (!h_av[t]) begin
                t++;
                continue;
            end
            r = t + 1;
            if (r < n) e_rd[r] = 1;
            if (r + 1 < n) e_fv[r + 1] = 1;
            for (int c = r + 1; c < n; c++) begin
                e_fl[c] = h_cl[r];
                e_fr[c] = h_cr[r];
            end
            ld = r + lat + 1;
            ws = ld + 1;
            if (ld >= n) break;
            dl = h_by[ld] ? h_cl[r] : h_fl[ld];
            dr = h_by[ld] ? h_cr[r] : h_fr[ld];
            found = 0;
            w = ws;
            while (w < ws + lim && w < n && !found) begin
                if (h_al[w]) found = 1;
                else w++;
            end
            if (found) begin
                if (w + 1 < n) begin
                    e_wr[w + 1]  = 1;
                    e_wl[w + 1]  = dl;
                    e_wrr[w + 1] = dr;
                end
                t = w + 2;
            end else if (ws + lim > n) begin
                break;
            end else begin
                if (ws + lim <= n - 1) e_drops++;
                t = ws + lim;
            end
        end
    endtask

    task automatic compare(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s strobes@%0d", tag, c),
                  32'({o_rd[c], o_wr[c], o_fv[c]}), 32'({e_rd[c], e_wr[c], e_fv[c]}));
            check($sformatf("%s fx_left_out@%0d", tag, c), o_fl[c], e_fl[c]);
            check($sformatf("%s fx_right_out@%0d", tag, c), o_fr[c], e_fr[c]);
            if (e_wr[c]) begin
                check($sformatf("%s codec_left_out@%0d", tag, c), o_cl[c], e_wl[c]);
                check($sformatf("%s codec_right_out@%0d", tag, c), o_cr[c], e_wrr[c]);
            end
        end
        check({tag, " drop_count"}, 32'(o_drop), 32'(e_drops));
    endtask

    function automatic int count_wr(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) k += int'(o_wr[c]);
        return k;
    endfunction

    function automatic int count_rd(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) k += int'(o_rd[c]);
        return k;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int lat[2];
        int lim[2];
        int last, bad;
        lat[0] = 2; lim[0] = 1023;
        lat[1] = 0; lim[1] = 4;
        tbl[0] = '{0, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_0ABC, 32'h0000_0DEF, 32'h0000_0ABC, 32'h0000_0DEF, 6};
        tbl[1] = '{0, 1'b1, 32'h0000_0001, 32'h8000_0005, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0001, 32'h8000_0005, 6};
        tbl[2] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4};
        tbl[3] = '{1, 1'b0, 32'h0000_0055, 32'h0000_00AA, 32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0001, 4};
        tbl[4] = '{0, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0001, 32'h0000_0002, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 6};
        tbl[5] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4};

        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            set_in(d, -1);
        end
        sat_clr = 1'b0;
        sat_inc = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check_zero("power-on reset", d);
            rstn[d] = 1'b1;
        end

        // Single samples with fixed data: timing and data path, both DUT configurations.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < MAXC; c++) begin
                h_av[c] = (c == 0); h_al[c] = 1'b1; h_by[c] = tbl[i].by;
                h_cl[c] = tbl[i].cl; h_cr[c] = tbl[i].cr;
                h_fl[c] = tbl[i].fl; h_fr[c] = tbl[i].fr;
            end
            run(tbl[i].d, 20, -1);
            check($sformatf("vec%0d read@1", i), 32'(o_rd[1]), 32'd1);
            check($sformatf("vec%0d fx_valid@2", i), 32'(o_fv[2]), 32'd1);
            check($sformatf("vec%0d write@%0d", i, tbl[i].wc), 32'(o_wr[tbl[i].wc]), 32'd1);
            check($sformatf("vec%0d write count", i), 32'(count_wr(20)), 32'd1);
            check($sformatf("vec%0d codec_left_out", i), o_cl[tbl[i].wc], tbl[i].el);
            check($sformatf("vec%0d codec_right_out", i), o_cr[tbl[i].wc], tbl[i].er);
            model(lat[tbl[i].d], lim[tbl[i].d], 20);
            compare($sformatf("vec%0d", i), 20);
        end

        // Back-pressure: ten stalled output cycles, then space appears at cycle 15.
        fill(0, 0, 0);
        h_av[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) h_al[c] = (c >= 15);
        run(0, 30, -1);
        check("backpressure write@16", 32'(o_wr[16]), 32'd1);
        check("backpressure write count", 32'(count_wr(30)), 32'd1);
        check("backpressure drop_count", 32'(o_drop), 32'd0);
        model(2, 1023, 30);
        compare("backpressure", 30);

        // Drop with STALL_LIMIT=4: output never allowed, next sample at cycle 10 still accepted.
        fill(0, 0, 0);
        h_av[0] = 1'b1;
        h_av[10] = 1'b1;
        run(1, 15, -1);
        check("drop write count", 32'(count_wr(15)), 32'd0);
        check("drop drop_count", 32'(o_drop), 32'd1);
        check("drop back to idle read@11", 32'(o_rd[11]), 32'd1);
        model(0, 4, 15);
        compare("drop", 15);

        // Saturation of the drop counter primitive.
        @(posedge clk); #1;
        check("sat cleared", 32'(sat_q), 32'd0);
        sat_clr = 1'b1;
        sat_inc = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("sat count 14", 32'(sat_q), 32'd14);
        repeat (6) @(posedge clk);
        #1;
        check("sat held at max", 32'(sat_q), 32'd15);
        sat_inc = 1'b0;

        // Reset while the sample sits in PROCESS.
        fill(0, 100, 0);
        h_av[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) h_cl[c] = 32'h1111_2222;
        run(0, 20, 3);
        check("midreset fx loaded before reset", o_fl[3], 32'h1111_2222);
        check("midreset no write", 32'(count_wr(20)), 32'd0);

        // Continuous input with FX_LATENCY=0: one sample every 5 cycles.
        fill(100, 100, 0);
        run(1, 500, -1);
        check("continuous reads", 32'(count_rd(500)), 32'd100);
        check("continuous writes", 32'(count_wr(500)), 32'd100);
        last = -1;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            if (o_rd[c]) begin
                if (last >= 0 && c - last != 5) bad++;
                last = c;
            end
        end
        check("continuous read period", 32'(bad), 32'd0);
        model(0, 4, 500);
        compare("continuous", 500);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 6; it++) begin
            int d = it % 2;
            fill(30, (d == 0) ? 50 : 25, 50);
            run(d, 1000, -1);
            model(lat[d], lim[d], 1000);
            compare($sformatf("random%0d", it), 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
